// File: rtl/bus_arbiter_n.sv
// ============================================================================
// bus_arbiter_n : round-robin arbiter sharing one dual-rail unit among USERS
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_arbiter_n #(
  parameter int USERS   = 4,
  parameter int INPUT   = 4,
  parameter int OUTPUT  = 4,
  parameter int TIMEOUT = 0,
  localparam int GW     = (USERS > 1) ? $clog2(USERS) : 1
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [USERS-1:0][INPUT-1:0][1:0]   user_input,
  output logic [USERS-1:0][OUTPUT-1:0][1:0]  user_output,
  output logic [INPUT-1:0][1:0]              in,
  input  logic [OUTPUT-1:0][1:0]             out,
  output logic                               busy,
  output logic [GW-1:0]                      grant_id,
  output logic                               timeout_error,
  output logic [7:0]                         stray_count
);

  localparam int            TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GLAST = GW'(USERS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                              state_q, state_d;
  logic [USERS-1:0][INPUT-1:0][1:0]    prev_in_q, prev_in_d;
  logic [OUTPUT-1:0][1:0]              prev_out_q, prev_out_d;
  logic [INPUT-1:0][1:0]               in_q, in_d;
  logic [USERS-1:0][OUTPUT-1:0][1:0]   user_output_q, user_output_d;
  logic                                busy_q, busy_d;
  logic [GW-1:0]                       grant_q, grant_d;
  logic [GW-1:0]                       last_grant_q, last_grant_d;
  logic                                timeout_error_q, timeout_error_d;
  logic [7:0]                          stray_q, stray_d;
  logic [TW-1:0]                       timer_q, timer_d;

  logic [USERS-1:0] w_req;
  logic             w_rsp;
  logic             w_found;
  logic [GW-1:0]    w_pick;
  int               w_idx;

  // A token has arrived only once every element differs from its last copy.
  always_comb begin
    w_req = '0;
    for (int u = 0; u < USERS; u++) begin
      w_req[u] = 1'b1;
      for (int e = 0; e < INPUT; e++) begin
        if (user_input[u][e] == prev_in_q[u][e]) w_req[u] = 1'b0;
      end
    end
    w_rsp = 1'b1;
    for (int e = 0; e < OUTPUT; e++) begin
      if (out[e] == prev_out_q[e]) w_rsp = 1'b0;
    end
  end

  // Scan starts just after the previous winner so every user gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 1; k <= USERS; k++) begin
      w_idx = (int'(last_grant_q) + k) % USERS;
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = GW'(w_idx);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    prev_in_d       = prev_in_q;
    prev_out_d      = prev_out_q;
    in_d            = in_q;
    user_output_d   = user_output_q;
    busy_d          = busy_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    timeout_error_d = timeout_error_q;
    stray_d         = stray_q;
    timer_d         = timer_q;
    case (state_q)
      IDLE: begin
        if (w_rsp) begin
          prev_out_d = out;
          if (stray_q != 8'hFF) stray_d = stray_q + 8'd1;
        end else if (w_found) begin
          in_d              = user_input[w_pick];
          prev_in_d[w_pick] = user_input[w_pick];
          grant_d           = w_pick;
          busy_d            = 1'b1;
          timer_d           = '0;
          state_d           = WAIT;
        end
      end
      WAIT: begin
        if (w_rsp) begin
          user_output_d[grant_q] = out;
          prev_out_d             = out;
          last_grant_d           = grant_q;
          busy_d                 = 1'b0;
          state_d                = IDLE;
        end else if ((TIMEOUT != 0) && (timer_q == TLAST)) begin
          // prev_out is left alone so a late answer is later seen as stray.
          timeout_error_d = 1'b1;
          last_grant_d    = grant_q;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      prev_in_q       <= user_input;
      prev_out_q      <= out;
      in_q            <= '0;
      user_output_q   <= '0;
      busy_q          <= 1'b0;
      grant_q         <= '0;
      last_grant_q    <= GLAST;
      timeout_error_q <= 1'b0;
      stray_q         <= 8'd0;
      timer_q         <= '0;
    end else begin
      state_q         <= state_d;
      prev_in_q       <= prev_in_d;
      prev_out_q      <= prev_out_d;
      in_q            <= in_d;
      user_output_q   <= user_output_d;
      busy_q          <= busy_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      timeout_error_q <= timeout_error_d;
      stray_q         <= stray_d;
      timer_q         <= timer_d;
    end
  end

  assign user_output   = user_output_q;
  assign in            = in_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;
  assign timeout_error = timeout_error_q;
  assign stray_count   = stray_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_n.sv
// ============================================================================
// tb_bus_arbiter_n : directed bench for bus_arbiter_n (USERS=4, TIMEOUT=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter_n;

  localparam int USERS   = 4;
  localparam int INPUT   = 4;
  localparam int OUTPUT  = 4;
  localparam int TIMEOUT = 8;

  logic                               clock = 1'b0;
  logic                               reset_n;
  logic [USERS-1:0][INPUT-1:0][1:0]   ui;
  logic [USERS-1:0][OUTPUT-1:0][1:0]  uo;
  logic [INPUT-1:0][1:0]              din;
  logic [OUTPUT-1:0][1:0]             ov;
  logic                               busy;
  logic [1:0]                         grant_id;
  logic                               toe;
  logic [7:0]                         stray;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_uo [USERS];

  bus_arbiter_n #(
    .USERS(USERS), .INPUT(INPUT), .OUTPUT(OUTPUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .user_input(ui), .user_output(uo),
    .in(din), .out(ov), .busy(busy), .grant_id(grant_id),
    .timeout_error(toe), .stray_count(stray)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_outputs(input string tag);
    for (int u = 0; u < USERS; u++) chk($sformatf("%s_uo%0d", tag, u), 32'(uo[u]), 32'(exp_uo[u]));
  endtask

  // Grant expected next edge; unit answers two cycles after the grant.
  task automatic serve(input int g, input logic [7:0] mask);
    tick();
    chk($sformatf("grant_busy_u%0d", g), 32'(busy), 32'd1);
    chk($sformatf("grant_id_u%0d", g), 32'(grant_id), 32'(g));
    chk($sformatf("grant_in_u%0d", g), 32'(din), 32'(ui[g]));
    tick();
    chk($sformatf("wait_busy_u%0d", g), 32'(busy), 32'd1);
    ov = ov ^ mask;
    tick();
    exp_uo[g] = ov;
    chk($sformatf("done_busy_u%0d", g), 32'(busy), 32'd0);
    chk_outputs($sformatf("done_u%0d", g));
  endtask

  initial begin
    reset_n = 1'b0;
    ui = {8'h96, 8'h0F, 8'hA5, 8'h3C};
    ov = 8'h71;
    for (int u = 0; u < USERS; u++) exp_uo[u] = 8'h00;

    // Reset state
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_toe", 32'(toe), 32'd0);
    chk("rst_stray", 32'(stray), 32'd0);
    chk("rst_in", 32'(din), 32'd0);
    chk_outputs("rst");
    reset_n = 1'b1;

    // Held inputs after reset: nothing happens
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
    end
    chk("idle_in", 32'(din), 32'd0);
    chk("idle_stray", 32'(stray), 32'd0);
    chk_outputs("idle");

    // Single request from user 2, answer three cycles later
    ui[2] = ui[2] ^ 8'h5A;
    tick();
    chk("u2_busy", 32'(busy), 32'd1);
    chk("u2_grant", 32'(grant_id), 32'd2);
    chk("u2_in", 32'(din), 32'(ui[2]));
    tick();
    tick();
    chk("u2_wait_busy", 32'(busy), 32'd1);
    ov = ov ^ 8'hB7;
    tick();
    exp_uo[2] = ov;
    chk("u2_done_busy", 32'(busy), 32'd0);
    chk("u2_done_grant", 32'(grant_id), 32'd2);
    chk_outputs("u2");

    // Reset pulse puts last_grant back to 3
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int u = 0; u < USERS; u++) exp_uo[u] = 8'h00;
    chk_outputs("rst2");

    // Users 0,1,3 together -> order 0,1,3
    ui[0] = ui[0] ^ 8'h5A;
    ui[1] = ui[1] ^ 8'hB7;
    ui[3] = ui[3] ^ 8'h6D;
    serve(0, 8'h5A);
    serve(1, 8'h6D);
    serve(3, 8'hB7);

    // All four together, last_grant=3 -> order 0,1,2,3
    ui[0] = ui[0] ^ 8'h6D;
    ui[1] = ui[1] ^ 8'h5A;
    ui[2] = ui[2] ^ 8'hB7;
    ui[3] = ui[3] ^ 8'h5A;
    serve(0, 8'hB7);
    serve(1, 8'h5A);
    serve(2, 8'h6D);
    serve(3, 8'h5A);

    // Timeout after 8 WAIT cycles, then late response is stray
    ui[0] = ui[0] ^ 8'hB7;
    tick();
    chk("to_busy", 32'(busy), 32'd1);
    chk("to_grant", 32'(grant_id), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("to_busy7", 32'(busy), 32'd1);
    chk("to_toe7", 32'(toe), 32'd0);
    tick();
    chk("to_toe8", 32'(toe), 32'd1);
    chk("to_busy8", 32'(busy), 32'd0);
    ov = ov ^ 8'h6D;
    tick();
    chk("late_stray", 32'(stray), 32'd1);
    chk("late_busy", 32'(busy), 32'd0);
    chk_outputs("late");
    tick();
    chk("late_stray_hold", 32'(stray), 32'd1);

    // Response and new request in the same WAIT cycle
    ui[3] = ui[3] ^ 8'h6D;
    tick();
    chk("sim_grant3", 32'(grant_id), 32'd3);
    tick();
    ov = ov ^ 8'h5A;
    ui[1] = ui[1] ^ 8'h6D;
    tick();
    exp_uo[3] = ov;
    chk("sim_done_busy", 32'(busy), 32'd0);
    chk_outputs("sim3");
    tick();
    chk("sim_busy1", 32'(busy), 32'd1);
    chk("sim_grant1", 32'(grant_id), 32'd1);
    chk("sim_in1", 32'(din), 32'(ui[1]));
    tick();
    ov = ov ^ 8'hB7;
    tick();
    exp_uo[1] = ov;
    chk("sim_done1_busy", 32'(busy), 32'd0);
    chk("sim_toe_sticky", 32'(toe), 32'd1);
    chk_outputs("sim1");

    // Reset mid-WAIT while the old response arrives
    ui[2] = ui[2] ^ 8'h5A;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_grant", 32'(grant_id), 32'd2);
    reset_n = 1'b0;
    ov = ov ^ 8'h6D;
    tick();
    reset_n = 1'b1;
    for (int u = 0; u < USERS; u++) exp_uo[u] = 8'h00;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in", 32'(din), 32'd0);
    chk("mid_rst_toe", 32'(toe), 32'd0);
    chk_outputs("mid_rst");
    for (int i = 0; i < 3; i++) tick();
    chk("mid_stray", 32'(stray), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);
    chk_outputs("mid_after");

    // 300 unsolicited tokens saturate the stray counter
    for (int i = 1; i <= 300; i++) begin
      ov = ov ^ (((i % 2) == 1) ? 8'h5A : 8'hB7);
      tick();
      if (i == 100) chk("stray_100", 32'(stray), 32'd100);
      if (i == 255) chk("stray_255", 32'(stray), 32'd255);
    end
    chk("stray_sat", 32'(stray), 32'd255);
    chk("stray_busy", 32'(busy), 32'd0);
    chk_outputs("stray");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
